gpio_input_sync_irq: RTL and testbench

//  Input path of the GPIO port. Per pin: synchroniser, debouncer, edge detect, sticky interrupt.

---
 rtl/gpio_input_sync_irq.sv | 91 +++++++++
 tb/tb_gpio_input_sync_irq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gpio_input_sync_irq.sv
// GPIO input path: per-pin synchroniser, debouncer, edge detector and sticky interrupt flags.
// gpio_data_in and irq are derived combinationally from registered state.
module gpio_input_sync_irq #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_pins,
    input  logic [WIDTH-1:0] gpio_dir,
    input  logic [WIDTH-1:0] irq_rise_en,
    input  logic [WIDTH-1:0] irq_fall_en,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] gpio_data_in,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_pins;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A pin is accepted on the edge where its differing level completes DEB_CYCLES samples.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise    = accept & sync;
    assign fall    = accept & ~sync;
    assign irq_set = ~gpio_dir & ((rise & irq_rise_en) | (fall & irq_fall_en));

    // Set has priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clear) | irq_set;
        end
    end

    assign gpio_data_in = stable & ~gpio_dir;
    assign irq          = |irq_status;

endmodule

// File: tb/tb_gpio_input_sync_irq.sv
// Directed bench for gpio_input_sync_irq: a vector table plus hand-written multi-cycle sequences.
module tb_gpio_input_sync_irq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] gpio_pins = '0;
    logic [15:0] gpio_dir = '0;
    logic [15:0] irq_rise_en = '0;
    logic [15:0] irq_fall_en = '0;
    logic [15:0] irq_clear = '0;
    logic [15:0] gpio_data_in;
    logic [15:0] irq_status;
    logic        irq;

    int total_cnt = 0;
    int pass_cnt  = 0;

    gpio_input_sync_irq #(
        .WIDTH(16),
        .SYNC_STAGES(2),
        .DEB_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gpio_pins(gpio_pins),
        .gpio_dir(gpio_dir),
        .irq_rise_en(irq_rise_en),
        .irq_fall_en(irq_fall_en),
        .irq_clear(irq_clear),
        .gpio_data_in(gpio_data_in),
        .irq_status(irq_status),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          do_rst;
        logic [15:0] pins;
        logic [15:0] dir;
        logic [15:0] rise_en;
        logic [15:0] fall_en;
        int          wait_cyc;
        logic [15:0] exp_data;
        logic [15:0] exp_status;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [7];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] d, input logic [15:0] s, input logic i);
        check({name, ".data"}, gpio_data_in, d);
        check({name, ".status"}, irq_status, s);
        check({name, ".irq"}, {15'd0, irq}, {15'd0, i});
    endtask

    initial begin
        vecs[0] = '{"dir_mask_rise", 1'b1, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 6, 16'hF0F0, 16'hF0F0, 1'b1};
        vecs[1] = '{"out_high",      1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{"out_low",       1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{"out_high2",     1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{"dir_to_in",     1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 16'h0000, 1'b0};
        vecs[5] = '{"fall_event",    1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 6, 16'h0000, 16'h00FF, 1'b1};
        vecs[6] = '{"en_off_keeps",  1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2, 16'h0000, 16'h00FF, 1'b1};

        // Reset state and exact latency of a clean step
        step(2);
        check_all("reset", 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;
        gpio_pins = 16'hAAAA;
        step(5);
        check("latency_early", gpio_data_in, 16'h0000);
        step(1);
        check("latency_exact", gpio_data_in, 16'hAAAA);

        // Glitch of 3 synced cycles is filtered, 4 is accepted
        irq_rise_en = 16'hFFFF;
        gpio_pins = 16'hAAAB;
        step(3);
        gpio_pins = 16'hAAAA;
        step(5);
        check_all("glitch3", 16'hAAAA, 16'h0000, 1'b0);
        gpio_pins = 16'hAAAB;
        step(4);
        gpio_pins = 16'hAAAA;
        step(2);
        check_all("pulse4", 16'hAAAB, 16'h0001, 1'b1);
        step(10);
        irq_clear = 16'hFFFF;
        step(1);
        irq_clear = 16'h0000;
        check("pulse4_clear", irq_status, 16'h0000);

        // Table of single-transition vectors
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].do_rst) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            gpio_pins   = vecs[v].pins;
            gpio_dir    = vecs[v].dir;
            irq_rise_en = vecs[v].rise_en;
            irq_fall_en = vecs[v].fall_en;
            irq_clear   = 16'h0000;
            step(vecs[v].wait_cyc);
            check_all(vecs[v].name, vecs[v].exp_data, vecs[v].exp_status, vecs[v].exp_irq);
        end

        // Reset mid-debounce with status 00FF; the count must restart from zero
        gpio_pins = 16'hFFFF;
        irq_fall_en = 16'h0000;
        step(4);
        rst = 1'b1;
        step(1);
        check_all("rst_mid", 16'h0000, 16'h0000, 1'b0);
        rst = 1'b0;
        step(5);
        check("rst_restart_early", gpio_data_in, 16'h0000);
        step(1);
        check("rst_restart_exact", gpio_data_in, 16'hFFFF);

        // Set and clear on the same edge: set wins
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        gpio_pins = 16'h0008;
        gpio_dir = 16'h0000;
        irq_rise_en = 16'h0000;
        irq_fall_en = 16'h0008;
        step(8);
        gpio_pins = 16'h0000;
        step(5);
        irq_clear = 16'h0008;
        step(1);
        irq_clear = 16'h0000;
        check("set_wins", irq_status, 16'h0008);
        irq_clear = 16'h0008;
        step(1);
        irq_clear = 16'h0000;
        check("later_clear", irq_status, 16'h0000);
        check("later_clear.irq", {15'd0, irq}, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
